// File: rtl/gba_eeprom_pkg.sv
// Shared types and constants for the GBA serial EEPROM emulator:
// engine states, DMA-length model detection and frame lengths.
package gba_eeprom_pkg;

  typedef enum logic [3:0] {
    INIT     = 4'd0,
    IDLE     = 4'd1,
    CMD2     = 4'd2,
    ADDR     = 4'd3,
    RD_STOP  = 4'd4,
    RD_FETCH = 4'd5,
    RD_HEAD  = 4'd6,
    RD_DATA  = 4'd7,
    WR_DATA  = 4'd8,
    WR_STOP  = 4'd9,
    BUSY     = 4'd10
  } state_e;

  localparam logic [16:0] DET_SMALL_A = 17'd9;
  localparam logic [16:0] DET_SMALL_B = 17'd73;
  localparam logic [16:0] DET_LARGE_A = 17'd17;
  localparam logic [16:0] DET_LARGE_B = 17'd81;

  localparam int HEAD_LEN = 4;
  localparam int DATA_LEN = 64;

  // Games size their DMA3 transfer to the command length, which reveals the model.
  function automatic logic is_large(input logic [16:0] count, input logic dflt);
    case (count)
      DET_SMALL_A, DET_SMALL_B: return 1'b0;
      DET_LARGE_A, DET_LARGE_B: return 1'b1;
      default:                  return dflt;
    endcase
  endfunction

endpackage

// File: rtl/eeprom_dpram_8.sv
// True dual-port byte RAM, 1-cycle read latency, read-first on both ports.
// Port A wins a same-address write collision; port B data output holds unless read.
module eeprom_dpram_8 #(
  parameter int BYTES = 8192,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  input  logic          b_re,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic [7:0]    b_rdata
);

  logic b_we_s;
  assign b_we_s = b_we & ~(a_we & (a_addr == b_addr));

`ifdef GBA_EEPROM_XPM
  xpm_memory_tdpram #(
    .MEMORY_SIZE        (BYTES * 8),
    .MEMORY_PRIMITIVE   ("block"),
    .CLOCKING_MODE      ("common_clock"),
    .ADDR_WIDTH_A       (AW),
    .ADDR_WIDTH_B       (AW),
    .WRITE_DATA_WIDTH_A (8),
    .WRITE_DATA_WIDTH_B (8),
    .READ_DATA_WIDTH_A  (8),
    .READ_DATA_WIDTH_B  (8),
    .BYTE_WRITE_WIDTH_A (8),
    .BYTE_WRITE_WIDTH_B (8),
    .READ_LATENCY_A     (1),
    .READ_LATENCY_B     (1),
    .WRITE_MODE_A       ("read_first"),
    .WRITE_MODE_B       ("read_first")
  ) u_xpm (
    .clka (clk), .clkb (clk), .rsta (~rst_n), .rstb (~rst_n),
    .ena (1'b1), .enb (b_re | b_we_s), .regcea (1'b1), .regceb (1'b1),
    .wea (a_we), .web (b_we_s), .addra (a_addr), .addrb (b_addr),
    .dina (a_wdata), .dinb (b_wdata), .douta (a_rdata), .doutb (b_rdata),
    .injectsbiterra (1'b0), .injectdbiterra (1'b0),
    .injectsbiterrb (1'b0), .injectdbiterrb (1'b0),
    .sleep (1'b0), .sbiterra (), .dbiterra (), .sbiterrb (), .dbiterrb ()
  );
`else
  logic [7:0] mem [BYTES];
  logic [7:0] a_rdata_d, a_rdata_q, b_rdata_d, b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we_s) mem[b_addr] <= b_wdata;
  end

  always_comb begin
    a_rdata_d = mem[a_addr];
    if (b_re) b_rdata_d = mem[b_addr];
    else      b_rdata_d = b_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
`endif

endmodule

// File: rtl/gba_eeprom_ser.sv
// GBA serial EEPROM command engine on the cartridge bit-0 interface, backed by a
// byte-wide dual-port RAM shared with the RV core; 64-bit writes commit atomically.
module gba_eeprom_ser
  import gba_eeprom_pkg::*;
#(
  parameter int          MEM_BYTES       = 8192,
  parameter int          ADDR_BITS_SMALL = 6,
  parameter int          ADDR_BITS_LARGE = 14,
  parameter int          BUSY_CYCLES     = 64,
  parameter logic [7:0]  INIT_FILL       = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs,
  input  logic                         model,
  input  logic [16:0]                  dma_eepromcount,
  input  logic                         valid,
  input  logic                         write,
  output logic                         ready,
  input  logic                         din,
  output logic                         dout,
  input  logic                         rv_rd,
  input  logic                         rv_wr,
  input  logic [$clog2(MEM_BYTES)-1:0] rv_addr,
  input  logic [7:0]                   rv_wdata,
  output logic [7:0]                   rv_rdata,
  output logic                         dirty,
  input  logic                         dirty_clr
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int BW = AW - 3;
  localparam int AB = ADDR_BITS_LARGE;
  localparam int CW = $clog2(MEM_BYTES + BUSY_CYCLES + 1);

  localparam logic [CW-1:0] INIT_LAST  = CW'(MEM_BYTES - 1);
  localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] FETCH_LAST = CW'(8);
  localparam logic [CW-1:0] HEAD_LAST  = CW'(HEAD_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0] SMALL_LAST = CW'(ADDR_BITS_SMALL - 1);
  localparam logic [CW-1:0] LARGE_LAST = CW'(ADDR_BITS_LARGE - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AB-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic [63:0]   buf_q, buf_d;
  logic          dirty_q, dirty_d;

  logic          acc_s, wr_acc_s, rd_acc_s, dout_s, dirty_set_s;
  logic          a_we_s;
  logic [AW-1:0] a_addr_s;
  logic [7:0]    a_wdata_s, a_rdata_s;

  assign acc_s    = valid & cs & (state_q != INIT) & (state_q != RD_FETCH);
  assign wr_acc_s = acc_s & write;
  assign rd_acc_s = acc_s & ~write;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    buf_d       = buf_q;
    dirty_set_s = 1'b0;
    dout_s      = 1'b0;
    a_we_s      = 1'b0;
    a_addr_s    = {addr_q[BW-1:0], cnt_q[2:0]};
    a_wdata_s   = buf_q[63:56];
    case (state_q)
      INIT: begin
        dout_s    = 1'b1;
        a_we_s    = 1'b1;
        a_addr_s  = cnt_q[AW-1:0];
        a_wdata_s = INIT_FILL;
        if (cnt_q == INIT_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      IDLE: begin
        dout_s = 1'b1;
        if (wr_acc_s && din) state_d = CMD2;
        else state_d = IDLE;
      end
      CMD2: if (wr_acc_s) begin
        cnt_d   = is_large(dma_eepromcount, model) ? LARGE_LAST : SMALL_LAST;
        addr_d  = '0;
        rd_d    = din;
        state_d = ADDR;
      end else state_d = CMD2;
      ADDR: if (wr_acc_s) begin
        addr_d = {addr_q[AB-2:0], din};
        if (cnt_q == CNT_ZERO) state_d = rd_q ? RD_STOP : WR_DATA;
        else cnt_d = cnt_q - CNT_ONE;
      end else state_d = ADDR;
      RD_STOP: if (wr_acc_s) begin
        state_d = RD_FETCH;
        cnt_d   = CNT_ZERO;
      end else state_d = RD_STOP;
      RD_FETCH: begin
        // Byte k is on the RAM output one clock after its address, so shifts lag by one.
        if (cnt_q != CNT_ZERO) buf_d = {buf_q[55:0], a_rdata_s};
        else buf_d = buf_q;
        if (cnt_q == FETCH_LAST) begin
          state_d = RD_HEAD;
          cnt_d   = CNT_ZERO;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      RD_HEAD: if (wr_acc_s) begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end else if (rd_acc_s) begin
        if (cnt_q == HEAD_LAST) begin
          state_d = RD_DATA;
          cnt_d   = CNT_ZERO;
        end else cnt_d = cnt_q + CNT_ONE;
      end else state_d = RD_HEAD;
      RD_DATA: begin
        dout_s = buf_q[63];
        if (wr_acc_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (rd_acc_s) begin
          buf_d = {buf_q[62:0], 1'b0};
          if (cnt_q == DATA_LAST) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else cnt_d = cnt_q + CNT_ONE;
        end else state_d = RD_DATA;
      end
      WR_DATA: if (wr_acc_s) begin
        buf_d = {buf_q[62:0], din};
        if (cnt_q == DATA_LAST) begin
          state_d = WR_STOP;
          cnt_d   = CNT_ZERO;
        end else cnt_d = cnt_q + CNT_ONE;
      end else state_d = WR_DATA;
      WR_STOP: if (wr_acc_s) begin
        state_d = din ? IDLE : BUSY;
        cnt_d   = CNT_ZERO;
      end else state_d = WR_STOP;
      BUSY: begin
        if (cnt_q < CW'(8)) begin
          a_we_s = 1'b1;
          buf_d  = {buf_q[55:0], 8'h00};
        end else a_we_s = 1'b0;
        dirty_set_s = (cnt_q == CNT_ZERO);
        if (cnt_q == BUSY_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else cnt_d = cnt_q + CNT_ONE;
      end
      default: begin
        state_d = INIT;
        cnt_d   = CNT_ZERO;
      end
    endcase
    dirty_d = dirty_set_s | (dirty_q & ~dirty_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= CNT_ZERO;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      buf_q   <= 64'h0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      buf_q   <= buf_d;
      dirty_q <= dirty_d;
    end
  end

  eeprom_dpram_8 #(.BYTES(MEM_BYTES), .AW(AW)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_we    (a_we_s),
    .a_addr  (a_addr_s),
    .a_wdata (a_wdata_s),
    .a_rdata (a_rdata_s),
    .b_re    (rv_rd),
    .b_we    (rv_wr),
    .b_addr  (rv_addr),
    .b_wdata (rv_wdata),
    .b_rdata (rv_rdata)
  );

  assign ready = acc_s;
  assign dout  = dout_s;
  assign dirty = dirty_q;

endmodule

// File: tb/tb_gba_eeprom_ser.sv
// Scoreboard bench for gba_eeprom_ser: stimulus pushes expected serial/RV read
// data into queues; negedge monitors pop and compare when the DUT presents data.
module tb_gba_eeprom_ser;

  localparam int MEM_BYTES = 8192;
  localparam int AW        = 13;

  logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b0, model = 1'b0;
  logic [16:0] dma_eepromcount = 17'd0;
  logic        valid = 1'b0, write = 1'b0, din = 1'b0;
  logic        rv_rd = 1'b0, rv_wr = 1'b0, dirty_clr = 1'b0;
  logic [AW-1:0] rv_addr = '0;
  logic [7:0]  rv_wdata = 8'h00;
  logic        ready, dout, dirty;
  logic [7:0]  rv_rdata;

  int   checks = 0, failures = 0, rd_seen = 0;
  bit   exp_dout_q[$];
  logic [7:0] exp_rv_q[$];
  logic rv_pend = 1'b0;

  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D2 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] D3 = 64'hA5C30F1E77889900;
  localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

  gba_eeprom_ser #(.MEM_BYTES(MEM_BYTES), .ADDR_BITS_SMALL(6), .ADDR_BITS_LARGE(14),
                   .BUSY_CYCLES(64), .INIT_FILL(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .model(model), .dma_eepromcount(dma_eepromcount),
    .valid(valid), .write(write), .ready(ready), .din(din), .dout(dout),
    .rv_rd(rv_rd), .rv_wr(rv_wr), .rv_addr(rv_addr), .rv_wdata(rv_wdata),
    .rv_rdata(rv_rdata), .dirty(dirty), .dirty_clr(dirty_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Serial read monitor
  always @(negedge clk) begin
    if (valid && cs && ready === 1'b1 && !write) begin
      rd_seen++;
      if (exp_dout_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL dout unexpected read #%0d got=%b exp=none", rd_seen, dout);
      end else check($sformatf("dout read #%0d", rd_seen), {63'd0, dout}, {63'd0, exp_dout_q.pop_front()});
    end
    if (rv_pend) begin
      if (exp_rv_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rv_rdata unexpected got=%0h exp=none", rv_rdata);
      end else check("rv_rdata", {56'd0, rv_rdata}, {56'd0, exp_rv_q.pop_front()});
    end
  end

  always @(posedge clk) rv_pend <= rv_rd;

  task automatic access(input logic w, input logic d, output int lows);
    bit ok;
    ok = 1'b0; lows = 0;
    valid = 1'b1; write = w; din = d;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (ready === 1'b1) ok = 1'b1; else lows++;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL access timeout got=no_ready exp=ready");
    end
  endtask

  task automatic wr(input logic d);
    int l;
    access(1'b1, d, l);
  endtask

  task automatic rd(input bit e);
    int l;
    exp_dout_q.push_back(e);
    access(1'b0, 1'b0, l);
  endtask

  task automatic send_cmd(input logic rdc, input int abits, input logic [13:0] a, input bit poke);
    wr(1'b1); wr(rdc);
    if (poke) rd(1'b0);
    for (int i = abits - 1; i >= 0; i--) wr(a[i]);
  endtask

  task automatic ser_write(input logic [16:0] cnt, input int abits, input logic [13:0] a,
                           input logic [63:0] d, input logic stop, input bit clr, input bit poke);
    dma_eepromcount = cnt;
    send_cmd(1'b0, abits, a, poke);
    for (int i = 63; i >= 0; i--) wr(d[i]);
    wr(stop);
    if (clr) begin
      dirty_clr = 1'b1;
      @(posedge clk); #1;
      dirty_clr = 1'b0;
    end
  endtask

  task automatic ser_read(input logic [16:0] cnt, input int abits, input logic [13:0] a,
                          input logic [63:0] d, input int nbits);
    int lows;
    dma_eepromcount = cnt;
    send_cmd(1'b1, abits, a, 1'b0);
    wr(1'b0);
    exp_dout_q.push_back(1'b0);
    access(1'b0, 1'b0, lows);
    check("fetch stall cycles", 64'(lows), 64'd9);
    for (int i = 0; i < 3; i++) rd(1'b0);
    for (int i = 0; i < nbits; i++) rd(d[63 - i]);
  endtask

  task automatic rv_read(input logic [AW-1:0] a, input logic [7:0] e);
    rv_addr = a; rv_rd = 1'b1;
    exp_rv_q.push_back(e);
    @(posedge clk); #1;
    rv_rd = 1'b0;
  endtask

  task automatic rv_write(input logic [AW-1:0] a, input logic [7:0] d);
    rv_addr = a; rv_wdata = d; rv_wr = 1'b1;
    @(posedge clk); #1;
    rv_wr = 1'b0;
  endtask

  task automatic rv_block(input logic [AW-1:0] base, input logic [63:0] d);
    for (int k = 0; k < 8; k++) rv_read(base + AW'(k), d[63 - 8*k -: 8]);
    @(posedge clk); #1;
  endtask

  task automatic busy_window();
    for (int i = 0; i < 64; i++) rd(1'b0);
    rd(1'b1);
  endtask

  initial begin
    int lows;
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("dirty after reset", {63'd0, dirty}, 64'd0);
    check("rv_rdata after reset", {56'd0, rv_rdata}, 64'd0);
    exp_dout_q.push_back(1'b1);
    access(1'b0, 1'b0, lows);
    check("init stall cycles", 64'(lows), 64'(MEM_BYTES));

    cs = 1'b0; valid = 1'b1; write = 1'b0;
    @(negedge clk);
    check("ready with cs low", {63'd0, ready}, 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; cs = 1'b1;
    rv_read(AW'(MEM_BYTES - 1), 8'hFF);
    rv_read(AW'(0), 8'hFF);
    @(posedge clk); #1;
    wr(1'b0); rd(1'b1);

    // Small write, commit, busy window, then readback through both ports
    ser_write(17'd73, 6, 14'h03, D1, 1'b0, 1'b0, 1'b0);
    busy_window();
    check("dirty after small commit", {63'd0, dirty}, 64'd1);
    rv_block(AW'(13'h18), D1);
    ser_read(17'd9, 6, 14'h03, D1, 64);
    rd(1'b1);

    dirty_clr = 1'b1; @(posedge clk); #1; dirty_clr = 1'b0;
    check("dirty after clear", {63'd0, dirty}, 64'd0);
    rv_write(AW'(13'h100), 8'h5A);
    check("dirty after rv write", {63'd0, dirty}, 64'd0);
    rv_read(AW'(13'h100), 8'h5A);

    // Discarded write (stop bit 1)
    ser_write(17'd73, 6, 14'h03, D2, 1'b1, 1'b0, 1'b0);
    rd(1'b1);
    check("dirty after discarded write", {63'd0, dirty}, 64'd0);
    rv_block(AW'(13'h18), D1);

    // Large write with dirty_clr in the commit cycle; read in ADDR returns 0
    ser_write(17'd81, 14, 14'h3FF, D3, 1'b0, 1'b1, 1'b1);
    check("dirty set wins over clr", {63'd0, dirty}, 64'd1);
    for (int i = 0; i < 63; i++) rd(1'b0);
    rd(1'b1);
    rv_block(AW'(13'h1FF8), D3);
    ser_read(17'd81, 14, 14'h3FF, D3, 64);
    rd(1'b1);

    // Write during RD_DATA aborts to IDLE
    ser_read(17'd9, 6, 14'h03, D1, 10);
    wr(1'b1);
    rd(1'b1);

    // Reset mid read, then INIT_FILL everywhere
    ser_read(17'd9, 6, 14'h03, D1, 20);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("dirty after mid-read reset", {63'd0, dirty}, 64'd0);
    ser_read(17'd9, 6, 14'h03, ONES, 64);
    rd(1'b1);
    rv_block(AW'(13'h1FF8), ONES);

    repeat (3) @(posedge clk);
    check("dout queue drained", 64'(exp_dout_q.size()), 64'd0);
    check("rv queue drained", 64'(exp_rv_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gba_eeprom_ser.md
Name: gba_eeprom_ser

Overview:
- Parametrised successor to the 1-bit GBA save EEPROM emulator. Serves GBA serial EEPROM commands on the cartridge bit-0 interface from a byte-wide dual-port BRAM.
- Adds valid/ready back-pressure, atomic buffered 64-bit writes, a programmable write-busy period, and a dirty flag for save persistence.
- A second byte port lets the RV core load and save the contents.

Parameters:
MEM_BYTES, 8192, backing store size in bytes; power of two, at least 512.
ADDR_BITS_SMALL, 6, serial address width for the 4Kbit model.
ADDR_BITS_LARGE, 14, serial address width for the 64Kbit model.
BUSY_CYCLES, 64, clocks after a write commit during which reads return 0; must be at least 9.
INIT_FILL, 8'hFF, byte value written to every location after reset.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cs  in  1  EEPROM region selected
model  in  1  default model: 0 = 4Kbit, 1 = 64Kbit
dma_eepromcount  in  17  current DMA3 length, used for model detection
valid  in  1  CPU serial access request
write  in  1  1 = bit write, 0 = bit read
ready  out  1  access accepted this cycle
din  in  1  serial write bit
dout  out  1  serial read bit; valid in the cycle ready is high
rv_rd  in  1  RV byte read strobe
rv_wr  in  1  RV byte write strobe
rv_addr  in  $clog2(MEM_BYTES)  RV byte address
rv_wdata  in  8  RV write data
rv_rdata  out  8  RV read data, 1-cycle latency
dirty  out  1  set by a committed serial write
dirty_clr  in  1  clears dirty

Behaviour:
- Reset values: state INIT, dirty 0, dout 1, ready 0, rv_rdata 0, all counters 0.
- rst_n low in any state, including mid-command or mid-commit, aborts the operation and restarts INIT. A partial commit is not completed.
- Handshake: ready = valid & cs & (state not in {INIT, RD_FETCH}). An access counts only in a cycle where ready is high.
- INIT: writes INIT_FILL to addresses 0..MEM_BYTES-1, one byte per clock, then goes to IDLE.
- IDLE: read returns dout=1. A write of din=1 goes to CMD2. A write of din=0 is ignored.
- CMD2 (on a write):
  - Latch the model. dma_eepromcount of 9 or 73 selects small; 17 or 81 selects large; any other value selects the model input.
  - Load the address counter with the width minus 1. Go to ADDR with rd = din.
- ADDR: shift din into the address MSB first. After the last bit, go to RD_STOP if rd, otherwise WR_DATA.
- Block index = address mod (MEM_BYTES/8). Byte address = block*8 + k.
- RD_STOP: one write of any value, then RD_FETCH.
- RD_FETCH: read bytes 0..7 of the block into a 64-bit shift register. Lasts 9 clocks because of BRAM latency; ready is low throughout. Then RD_HEAD.
- RD_HEAD: 4 reads return 0, then RD_DATA.
- RD_DATA: 64 reads. Transmission order is byte 0 bit 7 first through byte 7 bit 0. After the 64th read, go to IDLE.
- WR_DATA: 64 writes shift into the write buffer in the same bit order as reads. The BRAM is not touched in this state.
- WR_STOP:
  - A write of din=0 starts the commit and goes to BUSY.
  - A write of din=1 discards the buffer, leaves memory and dirty unchanged, and goes to IDLE.
- BUSY:
  - Counts BUSY_CYCLES clocks. The 8 commit byte writes occur in the first 8 clocks, and dirty is set on the first of them.
  - Reads return 0. Writes are ignored.
  - When the count expires, go to IDLE, where reads return 1.
- Protocol errors:
  - A read access in CMD2, ADDR, RD_STOP, WR_DATA or WR_STOP returns 0 and does not change state.
  - A write access in RD_HEAD or RD_DATA aborts to IDLE and is otherwise ignored.
- Ports: port A belongs to the serial engine, port B to RV. If both write the same byte in the same cycle, the serial write wins and the RV write is dropped. An RV read of a byte being written returns the old data.
- dirty:
  - dirty_clr and a commit set in the same cycle leave dirty=1.
  - RV writes never set dirty.
- cs low with valid high: no access, no state change, ready low.

Decomposition:
- Package gba_eeprom_pkg holds:
  - the state enum (INIT, IDLE, CMD2, ADDR, RD_STOP, RD_FETCH, RD_HEAD, RD_DATA, WR_DATA, WR_STOP, BUSY);
  - the detection counts 9, 73, 17 and 81;
  - the head length 4 and the data length 64.
- One sub-module, eeprom_dpram_8: a true dual-port byte RAM with 1-cycle read latency, a vendor macro for synthesis and a behavioural model for simulation.

Test Plan:
- Reset release with MEM_BYTES=512 → ready stays 0 for 512 clocks. Then an RV read of address 0x1FF returns 8'hFF and an IDLE serial read returns 1.
- Small write, dma_eepromcount=73: 2 bits "10", address 6'h03, data 64'h0123456789ABCDEF, stop 0 → dout reads 0 for 64 clocks and then 1. RV reads of 0x18..0x1F return 01 23 45 67 89 AB CD EF. dirty=1.
- Small read, dma_eepromcount=9, address 6'h03 → ready low for 9 clocks. Then 4 zeros, then 64 bits equal to 64'h0123456789ABCDEF MSB first. Then IDLE.
- Large write, dma_eepromcount=81, address 14'h3FF with MEM_BYTES=8192 → bytes 0x1FF8..0x1FFF are written. A following 14-bit read returns the same 64 bits.
- Write with stop bit 1 → memory unchanged, dirty unchanged, dout=1 on the next read. Separately, dirty_clr in the same cycle as a commit leaves dirty=1.
- rst_n low during RD_DATA bit 20 → INIT rerun. The following read command returns INIT_FILL data.
